// File: rtl/pause_unit_pkg.sv
// Shared types and constants for the decode-stage hazard unit: the per-stage
// destination tracking record and the liveness helper used by the forwarding muxes.
package pause_unit_pkg;

    typedef struct packed {
        logic [4:0] wa;
        logic       we;
        logic       is_load;
    } stage_rec_t;

    localparam int         REC_W      = $bits(stage_rec_t);
    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam stage_rec_t BUBBLE_REC = '{wa: 5'd0, we: 1'b0, is_load: 1'b0};

    // A record can only produce a hazard or a forward if it really writes a non-r0 register.
    function automatic logic rec_live(input stage_rec_t rec);
        return rec.we && (rec.wa != REG_ZERO);
    endfunction

    function automatic logic rec_hit(input stage_rec_t rec, input logic [4:0] ra);
        return rec_live(rec) && (rec.wa == ra);
    endfunction

endpackage

// File: rtl/pause_fwd_mux.sv
// Per-operand forwarding select: picks the youngest in-flight result for ra and
// flags when that youngest producer is a load still in EXE.
module pause_fwd_mux
    import pause_unit_pkg::*;
(
    input  logic [4:0]       ra,
    input  logic [31:0]      rd,
    input  logic [REC_W-1:0] rec_e,
    input  logic [REC_W-1:0] rec_m,
    input  logic [REC_W-1:0] rec_w,
    input  logic [31:0]      res_e,
    input  logic [31:0]      res_m,
    input  logic [31:0]      res_w,
    output logic [31:0]      fwd_data,
    output logic             load_hit
);

    stage_rec_t e_rec;
    stage_rec_t m_rec;
    stage_rec_t w_rec;
    logic       hit_e;
    logic       hit_m;
    logic       hit_w;
    logic       unused_load_bits;

    assign e_rec = stage_rec_t'(rec_e);
    assign m_rec = stage_rec_t'(rec_m);
    assign w_rec = stage_rec_t'(rec_w);

    // Only the EXE-stage load flag matters; older loads already have their data.
    assign unused_load_bits = m_rec.is_load ^ w_rec.is_load;

    assign hit_e = rec_hit(e_rec, ra);
    assign hit_m = rec_hit(m_rec, ra);
    assign hit_w = rec_hit(w_rec, ra);

    always_comb begin
        fwd_data = rd;
        if (ra == REG_ZERO) begin
            fwd_data = rd;
        end else if (hit_e) begin
            fwd_data = res_e;
        end else if (hit_m) begin
            fwd_data = res_m;
        end else if (hit_w) begin
            fwd_data = res_w;
        end
    end

    assign load_hit = hit_e && e_rec.is_load;

endmodule

// File: rtl/pause_unit.sv
// Decode-stage hazard unit: tracks EXE/MEM/WB destinations, forwards the newest
// in-flight result to both read operands and stalls one cycle on load-use.
module pause_unit
    import pause_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_PauseUnit_aluOutE,
    input  logic [31:0] i_PauseUnit_dMemRDataM,
    input  logic [31:0] i_PauseUnit_rstW,
    input  logic [4:0]  i_PauseUnit_ra1,
    input  logic [4:0]  i_PauseUnit_ra2,
    input  logic [31:0] i_PauseUnit_rd1,
    input  logic [31:0] i_PauseUnit_rd2,
    input  logic [4:0]  i_PauseUnit_regWa,
    input  logic        i_PauseUnit_regWe,
    input  logic        i_PauseUnit_isLoad,
    output logic        o_PauseUnit_pause,
    output logic [31:0] o_PauseUnit_rd1,
    output logic [31:0] o_PauseUnit_rd2
);

    stage_rec_t rec_e;
    stage_rec_t rec_m;
    stage_rec_t rec_w;
    stage_rec_t rec_e_nxt;
    stage_rec_t dec_rec;
    logic       load_hit1;
    logic       load_hit2;

    assign dec_rec = '{wa: i_PauseUnit_regWa, we: i_PauseUnit_regWe, is_load: i_PauseUnit_isLoad};

    // A paused decode instruction is held upstream, so EXE takes a bubble instead.
    assign rec_e_nxt = o_PauseUnit_pause ? BUBBLE_REC : dec_rec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rec_e <= BUBBLE_REC;
            rec_m <= BUBBLE_REC;
            rec_w <= BUBBLE_REC;
        end else begin
            rec_e <= rec_e_nxt;
            rec_m <= rec_e;
            rec_w <= rec_m;
        end
    end

    pause_fwd_mux u_fwd1 (
        .ra       (i_PauseUnit_ra1),
        .rd       (i_PauseUnit_rd1),
        .rec_e    (rec_e),
        .rec_m    (rec_m),
        .rec_w    (rec_w),
        .res_e    (i_PauseUnit_aluOutE),
        .res_m    (i_PauseUnit_dMemRDataM),
        .res_w    (i_PauseUnit_rstW),
        .fwd_data (o_PauseUnit_rd1),
        .load_hit (load_hit1)
    );

    pause_fwd_mux u_fwd2 (
        .ra       (i_PauseUnit_ra2),
        .rd       (i_PauseUnit_rd2),
        .rec_e    (rec_e),
        .rec_m    (rec_m),
        .rec_w    (rec_w),
        .res_e    (i_PauseUnit_aluOutE),
        .res_m    (i_PauseUnit_dMemRDataM),
        .res_w    (i_PauseUnit_rstW),
        .fwd_data (o_PauseUnit_rd2),
        .load_hit (load_hit2)
    );

    assign o_PauseUnit_pause = load_hit1 || load_hit2;

endmodule

// File: tb/tb_pause_unit.sv
// Directed bench for pause_unit: one table row per pipeline cycle, plus a
// hand-written load-use/reset sequence.
module tb_pause_unit;

    logic        clk;
    logic        rstn;
    logic [31:0] alu_out_e;
    logic [31:0] dmem_rdata_m;
    logic [31:0] rst_w;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  reg_wa;
    logic        reg_we;
    logic        is_load;
    logic        pause;
    logic [31:0] o_rd1;
    logic [31:0] o_rd2;

    int n_checks = 0;
    int n_errors = 0;

    pause_unit dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .i_PauseUnit_aluOutE   (alu_out_e),
        .i_PauseUnit_dMemRDataM(dmem_rdata_m),
        .i_PauseUnit_rstW      (rst_w),
        .i_PauseUnit_ra1       (ra1),
        .i_PauseUnit_ra2       (ra2),
        .i_PauseUnit_rd1       (rd1),
        .i_PauseUnit_rd2       (rd2),
        .i_PauseUnit_regWa     (reg_wa),
        .i_PauseUnit_regWe     (reg_we),
        .i_PauseUnit_isLoad    (is_load),
        .o_PauseUnit_pause     (pause),
        .o_PauseUnit_rd1       (o_rd1),
        .o_PauseUnit_rd2       (o_rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] exe;
        logic [31:0] mem;
        logic [31:0] wrt;
        logic [4:0]  wa;
        logic        we;
        logic        ld;
        logic        exp_pause;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input string name,
                                input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] ex, input logic [31:0] me, input logic [31:0] wb,
                                input logic [4:0] wa, input logic we, input logic ld,
                                input logic ep, input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.name = name; v.ra1 = a1; v.ra2 = a2; v.rd1 = d1; v.rd2 = d2;
        v.exe = ex; v.mem = me; v.wrt = wb; v.wa = wa; v.we = we; v.ld = ld;
        v.exp_pause = ep; v.exp_rd1 = e1; v.exp_rd2 = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ra1 = v.ra1; ra2 = v.ra2; rd1 = v.rd1; rd2 = v.rd2;
        alu_out_e = v.exe; dmem_rdata_m = v.mem; rst_w = v.wrt;
        reg_wa = v.wa; reg_we = v.we; is_load = v.ld;
    endtask

    task automatic check_vec(input vec_t v);
        check({v.name, ".pause"}, {31'd0, pause}, {31'd0, v.exp_pause});
        check({v.name, ".rd1"}, o_rd1, v.exp_rd1);
        check({v.name, ".rd2"}, o_rd2, v.exp_rd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // One row per cycle; issue fields (wa/we/ld) are latched at the end of the row.
        //                name          ra1 ra2 rd1     rd2     exe            mem        wrt        wa  we ld  pause rd1           rd2
        vecs[0]  = mk("idle",          0,  0,  0,      0,      0,             0,         0,         0,  0, 0,  0, 32'h0,        32'h0);
        vecs[1]  = mk("issue_r0",      0,  0,  0,      0,      32'hDEAD,      0,         0,         0,  1, 0,  0, 32'h0,        32'h0);
        vecs[2]  = mk("r0_no_fwd",     0,  0,  5,      6,      32'hDEAD,      32'hBEEF,  0,         1,  1, 0,  0, 32'h5,        32'h6);
        vecs[3]  = mk("no_match",      7,  8,  7,      8,      32'h11,        0,         0,         2,  1, 0,  0, 32'h7,        32'h8);
        vecs[4]  = mk("exe_mem_fwd",   1,  2,  32'hAA, 32'hBB, 32'h222,       32'h11,    0,         3,  1, 0,  0, 32'h11,       32'h222);
        vecs[5]  = mk("wb_exe_fwd",    1,  3,  32'hAA, 32'hBB, 32'h33,        32'h222,   32'h11,    1,  1, 0,  0, 32'h11,       32'h33);
        vecs[6]  = mk("exe_priority",  1,  2,  32'hAA, 32'hBB, 32'h66,        32'h55,    32'h44,    0,  0, 0,  0, 32'h66,       32'h44);
        vecs[7]  = mk("both_same_stg", 1,  1,  32'hAA, 32'hBB, 32'h99,        32'h77,    32'h88,    1,  1, 1,  0, 32'h77,       32'h77);
        vecs[8]  = mk("load_use",      1,  2,  32'hAA, 32'h222,32'h12345678,  32'h5,     32'h999,   5,  1, 0,  1, 32'h12345678, 32'h222);
        vecs[9]  = mk("load_resolved", 1,  2,  32'hAA, 32'h222,32'h12345678,  32'h111,   32'h999,   5,  1, 0,  0, 32'h111,      32'h222);
        vecs[10] = mk("load_in_wb",    4,  1,  32'h4,  32'h9,  32'h77,        32'h66,    32'h111,   0,  0, 0,  0, 32'h4,        32'h111);
        vecs[11] = mk("bubble_in_wb",  4,  1,  32'h4,  32'h9,  32'h77,        32'h66,    32'h111,   0,  1, 1,  0, 32'h4,        32'h9);
        vecs[12] = mk("r0_load_guard", 0,  0,  0,      0,      32'hDEAD,      32'hDEAD,  32'hDEAD,  0,  0, 0,  0, 32'h0,        32'h0);

        drive(vecs[0]);
        rstn = 1'b0;
        #12 rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            #3;
            check_vec(vecs[i]);
            @(posedge clk); #1;
        end

        // Load-use on operand 2 only, then reset while the pause is asserted.
        drive(mk("seq_issue", 0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk("seq_use", 0, 7, 32'h10, 32'h70, 32'hAB, 32'hCD, 32'hEF, 0, 0, 0, 0, 0, 0));
        #2;
        check("ld_ra2.pause", {31'd0, pause}, 32'd1);
        check("ld_ra2.rd2", o_rd2, 32'hAB);
        check("ld_ra2.rd1", o_rd1, 32'h10);
        rstn = 1'b0;
        #1;
        check("rst_async.pause", {31'd0, pause}, 32'd0);
        check("rst_async.rd2", o_rd2, 32'h70);
        @(posedge clk); #3;
        rstn = 1'b1;
        @(posedge clk); #2;
        dmem_rdata_m = 32'hCC;
        #1;
        check("post_rst.pause", {31'd0, pause}, 32'd0);
        check("post_rst.rd2", o_rd2, 32'h70);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
